i2c_bus_arbiter: RTL and testbench

//  Shares one I2C bus (SDA/SCL) between two I2C master FSMs (index 0, 1).

---
 rtl/i2c_bus_arbiter.sv | 113 +++++++++++
 tb/tb_i2c_bus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin owner selection and SDA/SCL mux for two I2C masters
// Optional watchdog on a held grant is enabled by defining ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int BUS_FREE       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic [1:0] m_sda,
  input  logic [1:0] m_scl,
  output logic       bus_sda,
  output logic       bus_scl,
  output logic [1:0] grant,
  output logic       arb_control,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HOLDOFF} state_t;

  localparam logic [CNT_W-1:0] FREE_LAST = CNT_W'(BUS_FREE - 1);
`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state;
  logic             last_owner;
  logic [CNT_W-1:0] counter;
  logic             owner_idx;
  logic             release_now;
  logic             next_owner;
  logic             cnt_max;

  assign owner_idx   = (state == GRANT1);
  assign release_now = done[owner_idx] || !req[owner_idx];
  // On a tie the master that did not own the bus last goes next.
  assign next_owner  = (req == 2'b11) ? ~last_owner : req[1];
  assign cnt_max     = &counter;

  always_comb begin
    bus_sda = 1'b1;
    bus_scl = 1'b1;
    case (state)
      GRANT0: begin
        bus_sda = m_sda[0];
        bus_scl = m_scl[0];
      end
      GRANT1: begin
        bus_sda = m_sda[1];
        bus_scl = m_scl[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      arb_control <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_owner  <= 1'b1;
      counter     <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (req != 2'b00) begin
            state       <= next_owner ? GRANT1 : GRANT0;
            grant       <= next_owner ? 2'b10 : 2'b01;
            arb_control <= next_owner;
            busy        <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (release_now) begin
            state      <= HOLDOFF;
            grant      <= 2'b00;
            last_owner <= owner_idx;
            counter    <= '0;
`ifdef ARB_TIMEOUT_EN
          end else if (counter == TO_LAST) begin
            state       <= HOLDOFF;
            grant       <= 2'b00;
            last_owner  <= owner_idx;
            counter     <= '0;
            timeout_err <= 1'b1;
          end else if (!cnt_max) begin
            counter <= counter + 1'b1;
`endif
          end
        end
        HOLDOFF: begin
          // Saturating so a huge BUS_FREE can never wrap into an early exit.
          if (counter == FREE_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else if (!cnt_max) begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - scoreboard bench for i2c_bus_arbiter with a cycle-count reference model
module tb_i2c_bus_arbiter;

  localparam int BF = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [1:0] m_sda = 2'b11;
  logic [1:0] m_scl = 2'b11;
  logic       bus_sda, bus_scl, arb_control, busy, timeout_err;
  logic [1:0] grant;

  i2c_bus_arbiter #(.BUS_FREE(BF), .TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .m_sda(m_sda), .m_scl(m_scl),
    .bus_sda(bus_sda), .bus_scl(bus_scl), .grant(grant), .arb_control(arb_control),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {grant, arb_control, busy, timeout_err, bus_sda, bus_scl}
  logic [6:0] exp_q[$];

  // Reference model: who owns the bus, how many holdoff cycles remain, how long held.
  int owner = -1;
  int gap = 0;
  int held = 0;
  int last = 1;
  int arb = 0;
  int terr = 0;

  task automatic model_edge();
    if (reset) begin
      owner = -1; gap = 0; held = 0; last = 1; arb = 0; terr = 0;
      return;
    end
    terr = 0;
    if (owner >= 0) begin
      if (done[owner] || !req[owner]) begin
        last = owner; owner = -1; gap = BF;
      end
`ifdef ARB_TIMEOUT_EN
      else if (held == TO - 1) begin
        last = owner; owner = -1; gap = BF; terr = 1;
      end
`endif
      else held++;
    end else if (gap > 0) begin
      gap--;
    end else if (req != 2'b00) begin
      if (req == 2'b11) owner = 1 - last;
      else owner = req[1] ? 1 : 0;
      held = 0;
      arb = owner;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [1:0] g;
    logic s, c;
    g = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    s = (owner >= 0) ? m_sda[owner] : 1'b1;
    c = (owner >= 0) ? m_scl[owner] : 1'b1;
    return {g, arb[0], (owner >= 0 || gap > 0), terr[0], s, c};
  endfunction

  task automatic step(input logic rs, input logic [1:0] r, input logic [1:0] d,
                      input logic [1:0] s, input logic [1:0] c);
    @(posedge clk);
    model_edge();
    #1;
    reset = rs; req = r; done = d; m_sda = s; m_scl = c;
    exp_q.push_back(model_out());
  endtask

  always @(negedge clk) begin
    logic [6:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {grant, arb_control, busy, timeout_err, bus_sda, bus_scl};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got grant=%b arb=%b busy=%b terr=%b sda=%b scl=%b expected grant=%b arb=%b busy=%b terr=%b sda=%b scl=%b",
                 $time, a[6:5], a[4], a[3], a[2], a[1], a[0], e[6:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  function automatic logic [1:0] rnd2();
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    // Reset held for a couple of cycles, then released.
    step(1'b1, 2'b00, 2'b00, 2'b11, 2'b11);
    step(1'b1, 2'b00, 2'b00, 2'b11, 2'b11);
    step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);

    // Single requester 0, bus follows master 0, then done pulse with req drop.
    for (int i = 0; i < 8; i++) step(1'b0, 2'b01, 2'b00, rnd2(), rnd2());
    step(1'b0, 2'b00, 2'b01, rnd2(), rnd2());
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 2'b00, rnd2(), rnd2());

    // Tie from idle: alternation across several releases via done of the owner.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 2'b00, rnd2(), rnd2());
      step(1'b0, 2'b11, (owner == 1) ? 2'b10 : 2'b01, rnd2(), rnd2());
    end
    for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 2'b00, rnd2(), rnd2());
    step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);

    // Non-owner done is ignored; owner req drop releases.
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 2'b00, rnd2(), rnd2());
    step(1'b0, 2'b01, 2'b10, rnd2(), rnd2());
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 2'b00, rnd2(), rnd2());
    step(1'b0, 2'b00, 2'b00, rnd2(), rnd2());
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 2'b00, rnd2(), rnd2());

    // Asynchronous reset in the middle of a GRANT1 transfer.
    for (int i = 0; i < 5; i++) step(1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || bus_sda !== 1'b1 || bus_scl !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got grant=%b sda=%b scl=%b busy=%b expected grant=00 sda=1 scl=1 busy=0",
               grant, bus_sda, bus_scl, busy);
    end
    step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);

    // Requester 1 held with no done: watchdog revokes when enabled, else held forever.
    for (int i = 0; i < 1000; i++) step(1'b0, 2'b10, 2'b00, rnd2(), rnd2());
    step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);

    // Randomized traffic: requests change rarely, done pulses occasionally.
    begin
      logic [1:0] r;
      logic [1:0] d;
      r = 2'b00;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) r = rnd2();
        d = ($urandom_range(0, 7) == 0) ? rnd2() : 2'b00;
        step(1'b0, r, d, rnd2(), rnd2());
      end
    end
    step(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);
    @(posedge clk);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
